sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO, next generation of the team's fixed 8-bit × 64 synchronous FIFO. Adds configurable data width and depth, programmable almost-full/almost-empty thresholds, an occupancy output, sticky overflow/underflow error flags, and an optional first-word-fall-through (FWFT) read mode. It sits between a single-clock producer and consumer as the standard buffering primitive for datapath blocks.

---
 rtl/sync_fifo_param_if.sv | 29 ++
 rtl/sync_fifo_param.sv | 94 +++++++++
 tb/tb_sync_fifo_param.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// Handshake bundle for sync_fifo_param: producer/consumer requests plus FIFO status.
// The master drives the requests; the slave (the FIFO) drives data out and status.
interface sync_fifo_param_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 64
);
    logic                     wr_en;
    logic [DATA_W-1:0]        wr_data;
    logic                     rd_en;
    logic                     err_clr;
    logic [DATA_W-1:0]        rd_data;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic                     almost_empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output wr_en, wr_data, rd_en, err_clr,
        input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, err_clr,
        output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with thresholds, occupancy, sticky error flags
// and optional first-word-fall-through read mode.
module sync_fifo_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned AF_LEVEL = DEPTH - 4,
    parameter int unsigned AE_LEVEL = 4,
    parameter int unsigned FWFT     = 0
) (
    input  logic             clk,
    input  logic             reset,
    sync_fifo_param_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              full, empty, wr_ok, rd_ok;

    // Status is decoded from registered count only, never from the requests.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign wr_ok = bus.wr_en && !full;
    assign rd_ok = bus.rd_en && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A rejection in the same cycle as err_clr keeps the flag set.
        if (bus.wr_en && full)       overflow_d = 1'b1;
        else if (bus.err_clr)        overflow_d = 1'b0;
        if (bus.rd_en && empty)      underflow_d = 1'b1;
        else if (bus.err_clr)        underflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= bus.wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.rd_data = empty ? '0 : mem[rd_ptr_q];
        end else begin : g_reg
            logic [DATA_W-1:0] rd_data_q;
            always_ff @(posedge clk) begin
                if (reset)      rd_data_q <= '0;
                else if (rd_ok) rd_data_q <= mem[rd_ptr_q];
            end
            assign bus.rd_data = rd_data_q;
        end
    endgenerate

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: registered-read 8x64 FIFO and FWFT 16x8 FIFO against
// queue-based reference models.
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(8),  .DEPTH(64)) bus_a ();
    sync_fifo_param_if #(.DATA_W(16), .DEPTH(8))  bus_b ();

    sync_fifo_param #(.DATA_W(8), .DEPTH(64), .AF_LEVEL(60), .AE_LEVEL(4), .FWFT(0)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave)
    );
    sync_fifo_param #(.DATA_W(16), .DEPTH(8), .AF_LEVEL(4), .AE_LEVEL(4), .FWFT(1)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave)
    );

    int errors = 0;
    int checks = 0;

    // Reference models: contents as queues, sticky flags, registered read word.
    logic [7:0]  qa[$];
    logic [7:0]  rda = '0;
    bit          ova = 0, uda = 0;
    logic [15:0] qb[$];
    bit          ovb = 0, udb = 0;

    function automatic logic [5:0] flags_a_exp();
        return {qa.size() == 64, qa.size() == 0, qa.size() >= 60, qa.size() <= 4, ova, uda};
    endfunction
    function automatic logic [5:0] flags_a_dut();
        return {bus_a.full, bus_a.empty, bus_a.almost_full, bus_a.almost_empty,
                bus_a.overflow, bus_a.underflow};
    endfunction
    function automatic logic [5:0] flags_b_exp();
        return {qb.size() == 8, qb.size() == 0, qb.size() >= 4, qb.size() <= 4, ovb, udb};
    endfunction
    function automatic logic [5:0] flags_b_dut();
        return {bus_b.full, bus_b.empty, bus_b.almost_full, bus_b.almost_empty,
                bus_b.overflow, bus_b.underflow};
    endfunction
    function automatic logic [15:0] rdb_exp();
        return (qb.size() != 0) ? qb[0] : 16'h0;
    endfunction

    task automatic idle_inputs();
        bus_a.wr_en = 0; bus_a.rd_en = 0; bus_a.err_clr = 0; bus_a.wr_data = '0;
        bus_b.wr_en = 0; bus_b.rd_en = 0; bus_b.err_clr = 0; bus_b.wr_data = '0;
    endtask

    // Drive one cycle on FIFO A and advance its model; outputs sampled 1 time unit after the edge.
    task automatic step_a(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
        bit was_full, was_empty;
        bus_a.wr_en = wr; bus_a.wr_data = d; bus_a.rd_en = rd; bus_a.err_clr = clr;
        @(posedge clk);
        was_full  = (qa.size() == 64);
        was_empty = (qa.size() == 0);
        if (rd && !was_empty) rda = qa.pop_front();
        if (wr && !was_full)  qa.push_back(d);
        if (wr && was_full) ova = 1; else if (clr) ova = 0;
        if (rd && was_empty) uda = 1; else if (clr) uda = 0;
        #1;
        bus_a.wr_en = 0; bus_a.rd_en = 0; bus_a.err_clr = 0;
    endtask

    task automatic step_b(input bit wr, input logic [15:0] d, input bit rd, input bit clr);
        bit was_full, was_empty;
        bus_b.wr_en = wr; bus_b.wr_data = d; bus_b.rd_en = rd; bus_b.err_clr = clr;
        @(posedge clk);
        was_full  = (qb.size() == 8);
        was_empty = (qb.size() == 0);
        if (rd && !was_empty) void'(qb.pop_front());
        if (wr && !was_full)  qb.push_back(d);
        if (wr && was_full) ovb = 1; else if (clr) ovb = 0;
        if (rd && was_empty) udb = 1; else if (clr) udb = 0;
        #1;
        bus_b.wr_en = 0; bus_b.rd_en = 0; bus_b.err_clr = 0;
    endtask

    // Requests currently on the buses stay applied during the reset edge.
    task automatic do_reset();
        reset = 1;
        @(posedge clk);
        qa.delete(); qb.delete();
        rda = '0; ova = 0; uda = 0; ovb = 0; udb = 0;
        #1;
        reset = 0;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        do_reset();
        checks++;
        if (bus_a.count !== 7'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", bus_a.count);
        end
        checks++;
        if (flags_a_dut() !== 6'b010100) begin
            errors++; $display("FAIL reset_flags_a: got %b expected 010100", flags_a_dut());
        end
        checks++;
        if (bus_a.rd_data !== 8'h00) begin
            errors++; $display("FAIL reset_rd_data_a: got %h expected 00", bus_a.rd_data);
        end
        checks++;
        if ({bus_b.rd_data, flags_b_dut()} !== {16'h0, 6'b010100}) begin
            errors++; $display("FAIL reset_b: got %h/%b expected 0000/010100",
                               bus_b.rd_data, flags_b_dut());
        end
    endtask

    task automatic test_fill();
        int af_at = -1;
        for (int i = 1; i <= 64; i++) begin
            step_a(1, 8'(i), 0, 0);
            if (bus_a.almost_full && af_at < 0) af_at = i;
            checks++;
            if (bus_a.count !== 7'(i)) begin
                errors++; $display("FAIL fill_count: got %0d expected %0d", bus_a.count, i);
            end
        end
        checks++;
        if (af_at !== 60) begin
            errors++; $display("FAIL fill_af_first: got %0d expected 60", af_at);
        end
        checks++;
        if (flags_a_dut() !== 6'b101000) begin
            errors++; $display("FAIL fill_full_flags: got %b expected 101000", flags_a_dut());
        end
        step_a(1, 8'hEE, 0, 0);
        checks++;
        if ({bus_a.count, bus_a.overflow} !== {7'd64, 1'b1}) begin
            errors++; $display("FAIL fill_overflow: got count=%0d ovf=%b expected 64/1",
                               bus_a.count, bus_a.overflow);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 64; i++) begin
            step_a(0, 8'h00, 1, 0);
            checks++;
            if (bus_a.rd_data !== 8'(i)) begin
                errors++; $display("FAIL drain_data: got %h expected %h", bus_a.rd_data, 8'(i));
            end
        end
        step_a(0, 8'h00, 1, 0);
        checks++;
        if ({bus_a.underflow, bus_a.rd_data, bus_a.empty} !== {1'b1, 8'h40, 1'b1}) begin
            errors++; $display("FAIL drain_underflow: got udf=%b data=%h empty=%b expected 1/40/1",
                               bus_a.underflow, bus_a.rd_data, bus_a.empty);
        end
        step_a(0, 8'h00, 0, 1);
        checks++;
        if ({bus_a.overflow, bus_a.underflow} !== 2'b00) begin
            errors++; $display("FAIL err_clr: got %b expected 00",
                               {bus_a.overflow, bus_a.underflow});
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) step_a(1, 8'($urandom), 0, 0);
        for (int i = 0; i < 200; i++) begin
            step_a(1, 8'($urandom), 1, 0);
            checks++;
            if ({bus_a.count, bus_a.rd_data, bus_a.overflow, bus_a.underflow} !==
                {7'd3, rda, 2'b00}) begin
                errors++; $display("FAIL stream: got cnt=%0d data=%h err=%b expected 3/%h/00",
                                   bus_a.count, bus_a.rd_data,
                                   {bus_a.overflow, bus_a.underflow}, rda);
            end
        end
        while (qa.size() != 0) step_a(0, 8'h00, 1, 0);
    endtask

    task automatic test_boundary();
        logic [7:0] held;
        for (int i = 0; i < 64; i++) step_a(1, 8'($urandom), 0, 0);
        step_a(1, 8'h5A, 1, 0);
        checks++;
        if ({bus_a.count, bus_a.overflow, bus_a.rd_data} !== {7'd63, 1'b1, rda}) begin
            errors++; $display("FAIL full_both: got cnt=%0d ovf=%b data=%h expected 63/1/%h",
                               bus_a.count, bus_a.overflow, bus_a.rd_data, rda);
        end
        while (qa.size() != 0) step_a(0, 8'h00, 1, 0);
        held = rda;
        step_a(1, 8'hA5, 1, 0);
        checks++;
        if ({bus_a.count, bus_a.underflow, bus_a.rd_data} !== {7'd1, 1'b1, held}) begin
            errors++; $display("FAIL empty_both: got cnt=%0d udf=%b data=%h expected 1/1/%h",
                               bus_a.count, bus_a.underflow, bus_a.rd_data, held);
        end
        // Rejected write and err_clr together: overflow must stay set.
        for (int i = 0; i < 63; i++) step_a(1, 8'($urandom), 0, 0);
        step_a(1, 8'h11, 0, 1);
        checks++;
        if ({bus_a.overflow, bus_a.underflow} !== 2'b10) begin
            errors++; $display("FAIL set_wins: got %b expected 10",
                               {bus_a.overflow, bus_a.underflow});
        end
    endtask

    task automatic test_random_a();
        int pw, pr;
        for (int i = 0; i < 500; i++) begin
            pw = (i < 250) ? 80 : 30;
            pr = (i < 250) ? 30 : 80;
            step_a($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
                   $urandom_range(0, 99) < 5);
            checks++;
            if ({bus_a.count, flags_a_dut(), bus_a.rd_data} !==
                {7'(qa.size()), flags_a_exp(), rda}) begin
                errors++; $display("FAIL random_a: got cnt=%0d flags=%b data=%h expected %0d/%b/%h",
                                   bus_a.count, flags_a_dut(), bus_a.rd_data,
                                   qa.size(), flags_a_exp(), rda);
            end
        end
    endtask

    task automatic test_fwft();
        do_reset();
        step_b(1, 16'hBEEF, 0, 0);
        checks++;
        if ({bus_b.empty, bus_b.rd_data} !== {1'b0, 16'hBEEF}) begin
            errors++; $display("FAIL fwft_write: got empty=%b data=%h expected 0/beef",
                               bus_b.empty, bus_b.rd_data);
        end
        step_b(0, 16'h0, 1, 0);
        checks++;
        if ({bus_b.empty, bus_b.rd_data} !== {1'b1, 16'h0}) begin
            errors++; $display("FAIL fwft_pop: got empty=%b data=%h expected 1/0000",
                               bus_b.empty, bus_b.rd_data);
        end
        for (int i = 0; i < 200; i++) begin
            step_b($urandom_range(0, 99) < 55, 16'($urandom), $urandom_range(0, 99) < 50,
                   $urandom_range(0, 99) < 5);
            checks++;
            if ({bus_b.count, flags_b_dut(), bus_b.rd_data} !==
                {4'(qb.size()), flags_b_exp(), rdb_exp()}) begin
                errors++; $display("FAIL random_b: got cnt=%0d flags=%b data=%h expected %0d/%b/%h",
                                   bus_b.count, flags_b_dut(), bus_b.rd_data,
                                   qb.size(), flags_b_exp(), rdb_exp());
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 5; i++) step_a(1, 8'h30 + 8'(i), 0, 0);
        step_a(0, 8'h00, 1, 0);
        step_a(1, 8'h77, 0, 0);
        bus_a.wr_en = 1; bus_a.wr_data = 8'h99; bus_a.rd_en = 1;
        do_reset();
        checks++;
        if ({bus_a.count, bus_a.empty, bus_a.rd_data} !== {7'd0, 1'b1, 8'h00}) begin
            errors++; $display("FAIL mid_reset: got cnt=%0d empty=%b data=%h expected 0/1/00",
                               bus_a.count, bus_a.empty, bus_a.rd_data);
        end
        step_a(1, 8'hC3, 0, 0);
        step_a(0, 8'h00, 1, 0);
        checks++;
        if ({bus_a.rd_data, bus_a.empty} !== {8'hC3, 1'b1}) begin
            errors++; $display("FAIL post_reset_data: got %h empty=%b expected c3/1",
                               bus_a.rd_data, bus_a.empty);
        end
    endtask

    initial begin
        idle_inputs();
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_boundary();
        test_random_a();
        test_fwft();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
